// File: rtl/snake_pkg.sv
// Shared snake-game definitions: coordinate width, playfield limits, cell pitch
// and the food spawner state encoding. Also used by random_point and the VGA renderer.
package snake_pkg;

    localparam int unsigned COORD_W = 10;

    // Cell pitch in pixels; every legal coordinate is a multiple of this.
    localparam logic [COORD_W-1:0] GRID  = 10'd10;

    // Playfield limits, all inclusive.
    localparam logic [COORD_W-1:0] X_MIN = 10'd30;
    localparam logic [COORD_W-1:0] X_MAX = 10'd610;
    localparam logic [COORD_W-1:0] Y_MIN = 10'd30;
    localparam logic [COORD_W-1:0] Y_MAX = 10'd450;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_QUERY  = 2'd2,
        ST_PLACED = 2'd3
    } state_t;

endpackage

// File: rtl/cell_legal_chk.sv
// Combinational legality check for a candidate cell: inside the playfield and
// aligned to the cell grid. GRID is a constant, so the modulo reduces to fixed logic.
module cell_legal_chk
    import snake_pkg::*;
(
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic               o_legal
);

    logic w_x_in_range;
    logic w_y_in_range;
    logic w_x_on_grid;
    logic w_y_on_grid;

    assign w_x_in_range = (i_x >= X_MIN) && (i_x <= X_MAX);
    assign w_y_in_range = (i_y >= Y_MIN) && (i_y <= Y_MAX);
    assign w_x_on_grid  = ((i_x % GRID) == '0);
    assign w_y_on_grid  = ((i_y % GRID) == '0);

    assign o_legal = w_x_in_range && w_y_in_range && w_x_on_grid && w_y_on_grid;

endmodule

// File: rtl/food_spawner.sv
// Food spawner: samples the free-running random candidate stream, rejects cells
// outside the playfield or off-grid, asks the body store whether a legal cell is
// free, publishes the food position, detects the head eating it, counts score and
// respawns. All outputs are registered.
module food_spawner
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 8,
    parameter int SCORE_W   = 8
)(
    input  logic               clk_vga,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               start,
    input  logic [COORD_W-1:0] rand_x,
    input  logic [COORD_W-1:0] rand_y,
    input  logic               head_valid,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic               food_valid,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               eaten,
    output logic [SCORE_W-1:0] score,
    output logic               spawn_fail
);

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    state_t             r_state;
    logic [COORD_W-1:0] r_cand_x;
    logic [COORD_W-1:0] r_cand_y;
    logic               r_occ_req;
    logic               r_food_valid;
    logic [COORD_W-1:0] r_food_x;
    logic [COORD_W-1:0] r_food_y;
    logic               r_eaten;
    logic [SCORE_W-1:0] r_score;
    logic               r_spawn_fail;
    logic [TRY_W-1:0]   r_tries;

    state_t             w_state_next;
    logic [COORD_W-1:0] w_cand_x_next;
    logic [COORD_W-1:0] w_cand_y_next;
    logic               w_occ_req_next;
    logic               w_food_valid_next;
    logic [COORD_W-1:0] w_food_x_next;
    logic [COORD_W-1:0] w_food_y_next;
    logic               w_eaten_next;
    logic [SCORE_W-1:0] w_score_next;
    logic               w_spawn_fail_next;
    logic [TRY_W-1:0]   w_tries_next;
    logic               w_reject;
    logic               w_rand_legal;
    logic               w_head_on_food;

    cell_legal_chk u_legal (
        .i_x     (rand_x),
        .i_y     (rand_y),
        .o_legal (w_rand_legal)
    );

    assign w_head_on_food = head_valid && (head_x == r_food_x) && (head_y == r_food_y);

    // Next-state, next-output and try/score counter logic; clear overrides everything.
    always_comb begin
        w_state_next      = r_state;
        w_cand_x_next     = r_cand_x;
        w_cand_y_next     = r_cand_y;
        w_occ_req_next    = r_occ_req;
        w_food_valid_next = r_food_valid;
        w_food_x_next     = r_food_x;
        w_food_y_next     = r_food_y;
        w_eaten_next      = 1'b0;
        w_score_next      = r_score;
        w_spawn_fail_next = 1'b0;
        w_tries_next      = r_tries;
        w_reject          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // The candidate is latched every sample cycle; occ_x/occ_y show it.
                w_cand_x_next = rand_x;
                w_cand_y_next = rand_y;
                if (w_rand_legal) begin
                    w_state_next   = ST_QUERY;
                    w_occ_req_next = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
            end
            ST_QUERY: begin
                if (occ_ack) begin
                    w_occ_req_next = 1'b0;
                    if (occ_hit) begin
                        w_state_next = ST_SAMPLE;
                        w_reject     = 1'b1;
                    end else begin
                        w_state_next      = ST_PLACED;
                        w_food_valid_next = 1'b1;
                        w_food_x_next     = r_cand_x;
                        w_food_y_next     = r_cand_y;
                        w_tries_next      = '0;
                    end
                end
            end
            ST_PLACED: begin
                if (w_head_on_food) begin
                    w_state_next      = ST_SAMPLE;
                    w_eaten_next      = 1'b1;
                    w_food_valid_next = 1'b0;
                    if (r_score != '1) begin
                        w_score_next = r_score + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Consecutive rejects wrap the counter and flag one spawn_fail pulse.
        if (w_reject) begin
            if (r_tries == TRY_LAST) begin
                w_tries_next      = '0;
                w_spawn_fail_next = 1'b1;
            end else begin
                w_tries_next = r_tries + 1'b1;
            end
        end

        if (clear) begin
            w_state_next      = ST_IDLE;
            w_cand_x_next     = '0;
            w_cand_y_next     = '0;
            w_occ_req_next    = 1'b0;
            w_food_valid_next = 1'b0;
            w_food_x_next     = '0;
            w_food_y_next     = '0;
            w_eaten_next      = 1'b0;
            w_score_next      = '0;
            w_spawn_fail_next = 1'b0;
            w_tries_next      = '0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_occ_req    <= 1'b0;
            r_food_valid <= 1'b0;
            r_food_x     <= '0;
            r_food_y     <= '0;
            r_eaten      <= 1'b0;
            r_score      <= '0;
            r_spawn_fail <= 1'b0;
            r_tries      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cand_x     <= w_cand_x_next;
            r_cand_y     <= w_cand_y_next;
            r_occ_req    <= w_occ_req_next;
            r_food_valid <= w_food_valid_next;
            r_food_x     <= w_food_x_next;
            r_food_y     <= w_food_y_next;
            r_eaten      <= w_eaten_next;
            r_score      <= w_score_next;
            r_spawn_fail <= w_spawn_fail_next;
            r_tries      <= w_tries_next;
        end
    end

    assign occ_req    = r_occ_req;
    assign occ_x      = r_cand_x;
    assign occ_y      = r_cand_y;
    assign food_valid = r_food_valid;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign eaten      = r_eaten;
    assign score      = r_score;
    assign spawn_fail = r_spawn_fail;

endmodule
